remote_load_wb: RTL and testbench
=================================

Name: remote_load_wb

Overview:
- Receiving end of the core's remote-request path. Accepts remote load responses returned from the network RX endpoint and buffers them in a small FIFO.
- Performs byte/half extraction and sign or zero extension per the returned load_info, then steers each result to one of three destinations: integer regfile writeback, float regfile writeback, or icache refill.
- Also owns the outstanding-remote-request credit counter that gates issue of new remote requests.

Parameters:
- data_width_p, 32, response data width; only 32 is supported.
- reg_addr_width_p, 5, destination register id width.
- fifo_els_p, 2, response buffer depth; must be at least 2.
- max_out_credits_p, 32, maximum number of in-flight remote requests.
- credit_width_lp, clog2(max_out_credits_p+1), width of the credit counter (localparam).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_issue_i  in  1  a remote request, including icache miss fetches, was accepted by network TX this cycle.
- resp_v_i  in  1  response valid.
- resp_ready_o  out  1  response can be accepted (FIFO not full).
- resp_data_i  in  32  raw 32-bit word from the target.
- resp_load_info_i  in  7  bsg_manycore_load_info_s: float_wb, icache_fetch, is_unsigned_op, is_byte_op, is_hex_op, part_sel[1:0].
- resp_reg_id_i  in  5  destination rd/frd.
- int_wb_v_o  out  1  integer writeback valid.
- int_wb_rd_o  out  5  integer writeback register.
- int_wb_data_o  out  32  integer writeback data.
- int_wb_yumi_i  in  1  integer writeback consumed.
- float_wb_v_o  out  1  float writeback valid.
- float_wb_rd_o  out  5  float writeback register.
- float_wb_data_o  out  32  float writeback data.
- float_wb_yumi_i  in  1  float writeback consumed.
- icache_v_o  out  1  icache refill valid.
- icache_data_o  out  32  icache refill word.
- icache_yumi_i  in  1  icache refill consumed.
- credit_avail_o  out  1  at least one credit is free; the LSU must not issue a remote request when this is 0.
- out_credits_o  out  credit_width_lp  current outstanding count.
- idle_o  out  1  FIFO empty and out_credits_o==0.

Behaviour:
- Reset values:
  - all *_v_o = 0 and FIFO emptied.
  - out_credits_o = 0, credit_avail_o = 1, idle_o = 1, resp_ready_o = 1.
- Handshake:
  - A response is enqueued when resp_v_i & resp_ready_o.
  - resp_ready_o = FIFO not full. There is no enqueue-while-full, even if a dequeue occurs in the same cycle.
- Latency: an enqueued response appears at the FIFO head no earlier than the next cycle (one-cycle minimum).
- Steering of the FIFO head (exactly one valid is asserted, the others are 0):
  - icache_fetch=1 -> icache. Data is the raw word; float_wb is ignored.
  - else float_wb=1 -> float. Data is the raw word; byte/hex flags are ignored.
  - else -> integer.
- Integer extraction:
  - byte: b = data[8*part_sel +: 8]; sign-extend unless is_unsigned_op.
  - hex: h = part_sel[1] ? data[31:16] : data[15:0]; extend likewise. part_sel[0] is ignored.
  - word: pass through unchanged.
- Dequeue:
  - Occurs when the yumi of the selected destination is 1.
  - A yumi on a non-selected destination is illegal (assertion).
  - Outputs are held stable while valid and not yumi'd.
- Credits:
  - +1 on req_issue_i.
  - -1 on response enqueue.
  - Both in the same cycle: unchanged.
  - credit_avail_o = out_credits_o < max_out_credits_p.
  - The following are assertion failures and the counter saturates: req_issue_i while count==max; enqueue while count==0.
- Reset asserted mid-operation: FIFO contents are dropped and credits cleared on the next edge. No partial writeback is emitted.

Optional Feature:
- Macro: REMOTE_LOAD_WB_BYPASS_EN.
- Defined:
  - When the FIFO is empty and resp_v_i=1, the response is steered and extracted combinationally in the same cycle (zero latency).
  - If the selected yumi arrives that cycle, the response is not enqueued. Credit still decrements on acceptance.
- Undefined: minimum latency is one cycle through the FIFO.

Decomposition:
- Use bsg_manycore_load_info_s from bsg_manycore_pkg.
- Add remote_load_wb_dest_e {e_wb_int, e_wb_float, e_wb_icache} to bsg_vanilla_pkg.
- FIFO: bsg_fifo_1r1w_small.
- Sub-module load_data_extract: combinational extraction/extension, reusable by the local-DMEM load path.

Test Plan:
- lb with part_sel=3, data=0x80FF_1234, signed -> int_wb_data_o=0xFFFF_FF80 to resp_reg_id_i. Same response with lbu -> 0x0000_0080.
- lh with part_sel=2, data=0x8001_7FFF -> 0xFFFF_8001. part_sel=0 -> 0x0000_7FFF. lhu with part_sel=2 -> 0x0000_8001.
- icache_fetch=1 and float_wb=1, data=0x0000_0013 -> only icache_v_o asserts, with 0x0000_0013. float_wb alone, rd=7 -> float_wb_rd_o=7 with the raw word.
- Hold int_wb_yumi_i=0 while sending 3 responses with fifo_els_p=2 -> resp_ready_o drops after 2 enqueues. Outputs stay stable, then drain in order when yumi is released.
- Issue 32 requests -> credit_avail_o=0. Same-cycle issue plus response -> count unchanged. 32 responses -> idle_o=1.
- Reset asserted with 2 entries buffered and 5 credits outstanding -> next cycle all valids are 0, out_credits_o=0, resp_ready_o=1.

Source files
------------

// File: rtl/remote_load_wb_pkg.sv
// Shared types for the remote load writeback path: returned load_info layout
// and writeback destination selection.
package remote_load_wb_pkg;

  typedef struct packed {
    logic       float_wb;
    logic       icache_fetch;
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } load_info_s;

  typedef enum logic [1:0] {
    e_wb_int,
    e_wb_float,
    e_wb_icache
  } remote_load_wb_dest_e;

  // icache refill outranks float writeback; everything else lands in the int regfile
  function automatic remote_load_wb_dest_e dest_of(input load_info_s info);
    if (info.icache_fetch)  return e_wb_icache;
    else if (info.float_wb) return e_wb_float;
    else                    return e_wb_int;
  endfunction

endpackage

// File: rtl/remote_load_wb_if.sv
// Response-in / writeback-out bundle between the network RX side, the
// regfiles / icache and remote_load_wb.
interface remote_load_wb_if
  import remote_load_wb_pkg::*;
#(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5
) ();

  logic                        resp_v;
  logic                        resp_ready;
  logic [data_width_p-1:0]     resp_data;
  load_info_s                  resp_load_info;
  logic [reg_addr_width_p-1:0] resp_reg_id;

  logic                        int_wb_v;
  logic [reg_addr_width_p-1:0] int_wb_rd;
  logic [data_width_p-1:0]     int_wb_data;
  logic                        int_wb_yumi;

  logic                        float_wb_v;
  logic [reg_addr_width_p-1:0] float_wb_rd;
  logic [data_width_p-1:0]     float_wb_data;
  logic                        float_wb_yumi;

  logic                        icache_v;
  logic [data_width_p-1:0]     icache_data;
  logic                        icache_yumi;

  modport slave (
    input  resp_v, resp_data, resp_load_info, resp_reg_id,
    input  int_wb_yumi, float_wb_yumi, icache_yumi,
    output resp_ready,
    output int_wb_v, int_wb_rd, int_wb_data,
    output float_wb_v, float_wb_rd, float_wb_data,
    output icache_v, icache_data
  );

  modport master (
    output resp_v, resp_data, resp_load_info, resp_reg_id,
    output int_wb_yumi, float_wb_yumi, icache_yumi,
    input  resp_ready,
    input  int_wb_v, int_wb_rd, int_wb_data,
    input  float_wb_v, float_wb_rd, float_wb_data,
    input  icache_v, icache_data
  );

endinterface

// File: rtl/remote_load_wb_extract.sv
// Combinational byte/half extraction with sign or zero extension; shared with
// the local DMEM load path.
module load_data_extract (
  input  logic [31:0] data,
  input  logic        is_byte_op,
  input  logic        is_hex_op,
  input  logic        is_unsigned_op,
  input  logic [1:0]  part_sel,
  output logic [31:0] result
);

  logic [7:0]  byte_val;
  logic [15:0] hex_val;

  always_comb begin
    byte_val = 8'(data >> {part_sel, 3'b000});
    hex_val  = part_sel[1] ? data[31:16] : data[15:0];
    if (is_byte_op)
      result = {{24{~is_unsigned_op & byte_val[7]}}, byte_val};
    else if (is_hex_op)
      result = {{16{~is_unsigned_op & hex_val[15]}}, hex_val};
    else
      result = data;
  end

endmodule

// File: rtl/remote_load_wb.sv
// Remote load response buffer, destination steering and outstanding-request
// credit counter. Define REMOTE_LOAD_WB_BYPASS_EN for a zero-latency empty-FIFO bypass.
module remote_load_wb
  import remote_load_wb_pkg::*;
#(
  parameter int data_width_p      = 32,
  parameter int reg_addr_width_p  = 5,
  parameter int fifo_els_p        = 2,
  parameter int max_out_credits_p = 32,
  localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       req_issue_i,
  remote_load_wb_if.slave            lsu,
  output logic                       credit_avail_o,
  output logic [credit_width_lp-1:0] out_credits_o,
  output logic                       idle_o
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

  typedef struct packed {
    logic [data_width_p-1:0]     data;
    load_info_s                  info;
    logic [reg_addr_width_p-1:0] reg_id;
  } entry_s;

  entry_s                mem [fifo_els_p];
  logic [ptr_w_lp-1:0]   rd_ptr, wr_ptr;
  logic [cnt_w_lp-1:0]   count;
  logic                  full, empty, enq, push, pop, deq;
  logic                  head_v, yumi_sel;
  entry_s                in_entry, head;
  remote_load_wb_dest_e  dest;
  logic [31:0]           int_data;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == cnt_w_lp'(fifo_els_p));
  assign empty    = (count == '0);
  assign in_entry = '{data: lsu.resp_data, info: lsu.resp_load_info, reg_id: lsu.resp_reg_id};

  assign lsu.resp_ready = ~full;
  assign enq            = lsu.resp_v & ~full;

`ifdef REMOTE_LOAD_WB_BYPASS_EN
  logic bypass;
  assign bypass = empty & lsu.resp_v;
  assign head   = bypass ? in_entry : mem[rd_ptr];
  assign head_v = ~empty | lsu.resp_v;
  // A bypassed response consumed in its arrival cycle never occupies a slot
  assign push   = enq & ~(bypass & deq);
  assign pop    = deq & ~bypass;
`else
  assign head   = mem[rd_ptr];
  assign head_v = ~empty;
  assign push   = enq;
  assign pop    = deq;
`endif

  assign dest = dest_of(head.info);

  always_comb begin
    yumi_sel = 1'b0;
    case (dest)
      e_wb_int:    yumi_sel = lsu.int_wb_yumi;
      e_wb_float:  yumi_sel = lsu.float_wb_yumi;
      e_wb_icache: yumi_sel = lsu.icache_yumi;
      default:     yumi_sel = 1'b0;
    endcase
  end

  assign deq = head_v & yumi_sel;

  load_data_extract extract (
    .data           (head.data),
    .is_byte_op     (head.info.is_byte_op),
    .is_hex_op      (head.info.is_hex_op),
    .is_unsigned_op (head.info.is_unsigned_op),
    .part_sel       (head.info.part_sel),
    .result         (int_data)
  );

  assign lsu.int_wb_v      = head_v & (dest == e_wb_int);
  assign lsu.int_wb_rd     = head.reg_id;
  assign lsu.int_wb_data   = int_data;
  assign lsu.float_wb_v    = head_v & (dest == e_wb_float);
  assign lsu.float_wb_rd   = head.reg_id;
  assign lsu.float_wb_data = head.data;
  assign lsu.icache_v      = head_v & (dest == e_wb_icache);
  assign lsu.icache_data   = head.data;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic credit_full, credit_zero;
  assign credit_full = (out_credits_o == credit_width_lp'(max_out_credits_p));
  assign credit_zero = (out_credits_o == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      out_credits_o <= '0;
    else if (req_issue_i & ~enq & ~credit_full)
      out_credits_o <= out_credits_o + 1'b1;
    else if (enq & ~req_issue_i & ~credit_zero)
      out_credits_o <= out_credits_o - 1'b1;
  end

  assign credit_avail_o = (out_credits_o < credit_width_lp'(max_out_credits_p));
  assign idle_o         = empty & credit_zero;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(req_issue_i & ~enq & credit_full));
      assert (!(enq & ~req_issue_i & credit_zero));
      assert (!(lsu.int_wb_yumi   & ~lsu.int_wb_v));
      assert (!(lsu.float_wb_yumi & ~lsu.float_wb_v));
      assert (!(lsu.icache_yumi   & ~lsu.icache_v));
    end
  end

endmodule

// File: tb/tb_remote_load_wb.sv
// Directed bench for remote_load_wb: extraction, steering, back-pressure,
// credit accounting and mid-operation reset.
module tb_remote_load_wb;
  import remote_load_wb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_issue;
  logic       credit_avail;
  logic [5:0] out_credits;
  logic       idle;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  remote_load_wb_if #(.data_width_p(32), .reg_addr_width_p(5)) bus ();

  remote_load_wb #(
    .data_width_p      (32),
    .reg_addr_width_p  (5),
    .fifo_els_p        (2),
    .max_out_credits_p (32)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_issue_i    (req_issue),
    .lsu            (bus),
    .credit_avail_o (credit_avail),
    .out_credits_o  (out_credits),
    .idle_o         (idle)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int n);
    req_issue = 1'b1;
    repeat (n) tick();
    req_issue = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [6:0] info, input logic [4:0] rd);
    int unsigned n = 0;
    bus.resp_v         = 1'b1;
    bus.resp_data      = d;
    bus.resp_load_info = info;
    bus.resp_reg_id    = rd;
    while (!bus.resp_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.resp_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout: resp_ready=%b required 1", bus.resp_ready);
    end
    tick();
    bus.resp_v = 1'b0;
  endtask

  task automatic test_reset;
    checks += 6;
    if ({bus.int_wb_v, bus.float_wb_v, bus.icache_v} !== 3'b000) begin
      failures++; $display("FAIL reset_valids: got %b required 000", {bus.int_wb_v, bus.float_wb_v, bus.icache_v});
    end
    if (out_credits !== 6'd0) begin
      failures++; $display("FAIL reset_credits: got %0d required 0", out_credits);
    end
    if (credit_avail !== 1'b1) begin
      failures++; $display("FAIL reset_credit_avail: got %b required 1", credit_avail);
    end
    if (idle !== 1'b1) begin
      failures++; $display("FAIL reset_idle: got %b required 1", idle);
    end
    if (bus.resp_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b required 1", bus.resp_ready);
    end
    if (dut.count !== '0) begin
      failures++; $display("FAIL reset_fifo_empty: got %0d required 0", dut.count);
    end
  endtask

  task automatic test_latency;
    issue(1);
    bus.resp_v = 1'b1; bus.resp_data = 32'hCAFE_0001;
    bus.resp_load_info = 7'h00; bus.resp_reg_id = 5'd4;
    #1;
    checks++;
`ifdef REMOTE_LOAD_WB_BYPASS_EN
    if (bus.int_wb_v !== 1'b1) begin
      failures++; $display("FAIL bypass_same_cycle: int_wb_v=%b required 1", bus.int_wb_v);
    end
`else
    if (bus.int_wb_v !== 1'b0) begin
      failures++; $display("FAIL latency_same_cycle: int_wb_v=%b required 0", bus.int_wb_v);
    end
`endif
    tick();
    bus.resp_v = 1'b0;
    checks++;
    if (bus.int_wb_v !== 1'b1 || bus.int_wb_data !== 32'hCAFE_0001 || bus.int_wb_rd !== 5'd4) begin
      failures++; $display("FAIL latency_next_cycle: v=%b data=%h rd=%0d required 1 cafe0001 4",
                           bus.int_wb_v, bus.int_wb_data, bus.int_wb_rd);
    end
    bus.int_wb_yumi = 1'b1; tick(); bus.int_wb_yumi = 1'b0;
  endtask

  task automatic test_int_extract;
    logic [31:0] d   [8];
    logic [6:0]  inf [8];
    logic [31:0] exp [8];
    d   = '{32'h80FF_1234, 32'h80FF_1234, 32'h8001_7FFF, 32'h8001_7FFF,
            32'h8001_7FFF, 32'h80FF_1234, 32'h8001_7FFF, 32'hDEAD_BEEF};
    // {float_wb, icache_fetch, unsigned, byte, hex, part_sel}
    inf = '{7'h0B, 7'h1B, 7'h06, 7'h04, 7'h16, 7'h09, 7'h07, 7'h00};
    exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF,
            32'h0000_8001, 32'h0000_0012, 32'hFFFF_8001, 32'hDEAD_BEEF};
    issue(8);
    for (int i = 0; i < 8; i++) begin
      send(d[i], inf[i], 5'(i + 10));
      checks++;
      if (bus.int_wb_v !== 1'b1 || bus.float_wb_v !== 1'b0 || bus.icache_v !== 1'b0 ||
          bus.int_wb_data !== exp[i] || bus.int_wb_rd !== 5'(i + 10)) begin
        failures++;
        $display("FAIL int_extract[%0d]: v=%b%b%b data=%h rd=%0d required 100 %h %0d", i,
                 bus.int_wb_v, bus.float_wb_v, bus.icache_v, bus.int_wb_data, bus.int_wb_rd,
                 exp[i], i + 10);
      end
      bus.int_wb_yumi = 1'b1; tick(); bus.int_wb_yumi = 1'b0;
    end
  endtask

  task automatic test_steering;
    issue(2);
    send(32'h0000_0013, 7'h60, 5'd9);
    checks++;
    if ({bus.int_wb_v, bus.float_wb_v, bus.icache_v} !== 3'b001 || bus.icache_data !== 32'h0000_0013) begin
      failures++; $display("FAIL icache_steer: v=%b data=%h required 001 00000013",
                           {bus.int_wb_v, bus.float_wb_v, bus.icache_v}, bus.icache_data);
    end
    bus.icache_yumi = 1'b1; tick(); bus.icache_yumi = 1'b0;
    send(32'h80FF_1234, 7'h5B, 5'd7);
    checks++;
    if ({bus.int_wb_v, bus.float_wb_v, bus.icache_v} !== 3'b010 ||
        bus.float_wb_rd !== 5'd7 || bus.float_wb_data !== 32'h80FF_1234) begin
      failures++; $display("FAIL float_steer: v=%b rd=%0d data=%h required 010 7 80ff1234",
                           {bus.int_wb_v, bus.float_wb_v, bus.icache_v}, bus.float_wb_rd, bus.float_wb_data);
    end
    bus.float_wb_yumi = 1'b1; tick(); bus.float_wb_yumi = 1'b0;
    checks++;
    if (idle !== 1'b1) begin
      failures++; $display("FAIL steer_drained_idle: got %b required 1", idle);
    end
  endtask

  task automatic test_back_to_back;
    issue(3);
    send(32'h1111_1111, 7'h00, 5'd1);
    send(32'h2222_2222, 7'h00, 5'd2);
    bus.resp_v = 1'b1; bus.resp_data = 32'h3333_3333;
    bus.resp_load_info = 7'h00; bus.resp_reg_id = 5'd3;
    checks++;
    if (bus.resp_ready !== 1'b0 || bus.int_wb_data !== 32'h1111_1111 || bus.int_wb_rd !== 5'd1) begin
      failures++; $display("FAIL full_hold0: ready=%b data=%h rd=%0d required 0 11111111 1",
                           bus.resp_ready, bus.int_wb_data, bus.int_wb_rd);
    end
    tick();
    checks++;
    if (bus.resp_ready !== 1'b0 || bus.int_wb_v !== 1'b1 || bus.int_wb_data !== 32'h1111_1111) begin
      failures++; $display("FAIL full_hold1: ready=%b v=%b data=%h required 0 1 11111111",
                           bus.resp_ready, bus.int_wb_v, bus.int_wb_data);
    end
    // pop while full: the waiting response must not slip in on the same edge
    bus.int_wb_yumi = 1'b1; tick(); bus.int_wb_yumi = 1'b0;
    checks++;
    if (bus.int_wb_data !== 32'h2222_2222 || bus.int_wb_rd !== 5'd2 ||
        bus.resp_ready !== 1'b1 || out_credits !== 6'd1) begin
      failures++; $display("FAIL drain_second: data=%h rd=%0d ready=%b credits=%0d required 22222222 2 1 1",
                           bus.int_wb_data, bus.int_wb_rd, bus.resp_ready, out_credits);
    end
    tick();
    bus.resp_v = 1'b0;
    checks++;
    if (out_credits !== 6'd0 || bus.int_wb_data !== 32'h2222_2222) begin
      failures++; $display("FAIL third_enq: credits=%0d data=%h required 0 22222222",
                           out_credits, bus.int_wb_data);
    end
    bus.int_wb_yumi = 1'b1; tick(); bus.int_wb_yumi = 1'b0;
    checks++;
    if (bus.int_wb_v !== 1'b1 || bus.int_wb_data !== 32'h3333_3333 || bus.int_wb_rd !== 5'd3) begin
      failures++; $display("FAIL drain_third: v=%b data=%h rd=%0d required 1 33333333 3",
                           bus.int_wb_v, bus.int_wb_data, bus.int_wb_rd);
    end
    bus.int_wb_yumi = 1'b1; tick(); bus.int_wb_yumi = 1'b0;
    checks++;
    if (bus.int_wb_v !== 1'b0 || idle !== 1'b1) begin
      failures++; $display("FAIL drain_empty: v=%b idle=%b required 0 1", bus.int_wb_v, idle);
    end
  endtask

  task automatic test_credits;
    issue(32);
    checks++;
    if (out_credits !== 6'd32 || credit_avail !== 1'b0 || idle !== 1'b0) begin
      failures++; $display("FAIL credits_max: count=%0d avail=%b idle=%b required 32 0 0",
                           out_credits, credit_avail, idle);
    end
    req_issue = 1'b1;
    send(32'h0000_00AA, 7'h00, 5'd5);
    req_issue = 1'b0;
    checks++;
    if (out_credits !== 6'd32) begin
      failures++; $display("FAIL credits_issue_and_resp: count=%0d required 32", out_credits);
    end
    bus.int_wb_yumi = 1'b1; tick(); bus.int_wb_yumi = 1'b0;
    for (int i = 0; i < 32; i++) begin
      send(32'(i), 7'h00, 5'd6);
      if (i == 0) begin
        checks++;
        if (out_credits !== 6'd31 || credit_avail !== 1'b1) begin
          failures++; $display("FAIL credits_first_return: count=%0d avail=%b required 31 1",
                               out_credits, credit_avail);
        end
      end
      bus.int_wb_yumi = 1'b1; tick(); bus.int_wb_yumi = 1'b0;
    end
    checks++;
    if (out_credits !== 6'd0 || idle !== 1'b1 || credit_avail !== 1'b1) begin
      failures++; $display("FAIL credits_drained: count=%0d idle=%b avail=%b required 0 1 1",
                           out_credits, idle, credit_avail);
    end
  endtask

  task automatic test_reset_mid;
    issue(7);
    send(32'hAAAA_0001, 7'h00, 5'd1);
    send(32'hAAAA_0002, 7'h40, 5'd2);
    checks++;
    if (out_credits !== 6'd5 || bus.resp_ready !== 1'b0) begin
      failures++; $display("FAIL pre_reset: credits=%0d ready=%b required 5 0", out_credits, bus.resp_ready);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.int_wb_v, bus.float_wb_v, bus.icache_v} !== 3'b000 || out_credits !== 6'd0 ||
        bus.resp_ready !== 1'b1 || idle !== 1'b1) begin
      failures++; $display("FAIL mid_reset: v=%b credits=%0d ready=%b idle=%b required 000 0 1 1",
                           {bus.int_wb_v, bus.float_wb_v, bus.icache_v}, out_credits, bus.resp_ready, idle);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.int_wb_v, bus.float_wb_v, bus.icache_v} !== 3'b000) begin
      failures++; $display("FAIL post_reset_valids: v=%b required 000",
                           {bus.int_wb_v, bus.float_wb_v, bus.icache_v});
    end
  endtask

  initial begin
    reset = 1'b1; req_issue = 1'b0;
    bus.resp_v = 1'b0; bus.resp_data = '0; bus.resp_load_info = '0; bus.resp_reg_id = '0;
    bus.int_wb_yumi = 1'b0; bus.float_wb_yumi = 1'b0; bus.icache_yumi = 1'b0;
    tick(); tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_latency();
    test_int_extract();
    test_steering();
    test_back_to_back();
    test_credits();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
